serial_adder_ctrl: RTL and testbench

//   Bit-serial adder. Accepts two WIDTH-bit operands plus carry-in on a start

---
 rtl/serial_adder_ctrl.sv | 105 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: captures two WIDTH-bit operands and a carry-in on start,
// then resolves one full-adder bit per clock, LSB first, with busy/done flags.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             c;
    logic [CW-1:0]    cnt;

    logic             accept_c;
    logic             last_c;
    logic             bit_c;
    logic             carry_c;

    // Full-adder slice on the current LSBs
    always_comb begin
        bit_c   = sa[0] ^ sb[0] ^ c;
        carry_c = (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));
        last_c  = (cnt == CW'(WIDTH - 1));
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_c  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_c) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
        end
    end

    // Result bits are shifted into the vacated MSBs of sa, so after WIDTH
    // steps sa holds the sum without a separate result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa   <= '0;
            sb   <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else if (accept_c) begin
            sa  <= a;
            sb  <= b;
            c   <= cin;
            cnt <= '0;
        end else if (state == RUN) begin
            sa  <= {bit_c, sa[WIDTH-1:1]};
            sb  <= sb >> 1;
            c   <= carry_c;
            cnt <= cnt + CW'(1);
            if (last_c) begin
                sum  <= {bit_c, sa[WIDTH-1:1]};
                cout <= carry_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: WIDTH=8 vector table, held-start
// throughput, mid-run reset, and WIDTH=3 exhaustive sweep.
module tb_serial_adder_ctrl;

    localparam int W8 = 8;
    localparam int W3 = 3;
    localparam int NVEC = 24;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start3, cin3, busy3, done3, cout3;
    logic [2:0] a3, b3, sum3;

    int nchk = 0;
    int nerr = 0;
    int pulses3 = 0;
    logic [8:0] held;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl [NVEC];

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(W3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
        .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
    );

    always @(negedge clk) if (done3) pulses3++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One WIDTH=8 operation; noisy toggles start and operands while running
    task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                           input logic [8:0] texp, input bit noisy);
        int   e;
        logic busy_bad;
        logic hold_bad;
        busy_bad = 1'b0;
        hold_bad = 1'b0;
        @(negedge clk);
        a8 = ta; b8 = tb_; cin8 = tc; start8 = 1'b1;
        @(negedge clk);
        e = 0;
        while (!done8 && e < 40) begin
            if (busy8 !== 1'b1) busy_bad = 1'b1;
            if ({cout8, sum8} !== held) hold_bad = 1'b1;
            start8 = noisy ? 1'($urandom) : 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            @(negedge clk);
            e++;
        end
        start8 = 1'b0;
        chk("latency", 64'(e), 64'(W8));
        chk("busy_during_run", busy_bad, 1'b0);
        chk("no_intermediate", hold_bad, 1'b0);
        chk("busy_at_done", busy8, 1'b0);
        chk("result", {cout8, sum8}, texp);
        @(negedge clk);
        chk("done_one_cycle", done8, 1'b0);
        chk("result_held", {cout8, sum8}, texp);
        held = texp;
    endtask

    task automatic run_op3(input logic [2:0] ta, input logic [2:0] tb_, input logic tc);
        int e;
        @(negedge clk);
        a3 = ta; b3 = tb_; cin3 = tc; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        e = 0;
        while (!done3 && e < 20) begin
            @(negedge clk);
            e++;
        end
        chk("w3_latency", 64'(e), 64'(W3));
        chk("w3_result", {cout3, sum3}, 4'(ta) + 4'(tb_) + 4'(tc));
    endtask

    initial begin
        logic [7:0] ca, cb;
        logic       cc;
        logic [8:0] expq [$];
        int         last;
        int         since;
        int         accepts;
        logic       abort_done;

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
        held = '0;

        tbl[0] = '{8'h5A, 8'h3C, 1'b0, 9'h096};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 9'h100};
        tbl[2] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
        tbl[3] = '{8'h00, 8'h00, 1'b0, 9'h000};
        tbl[4] = '{8'h80, 8'h80, 1'b1, 9'h101};
        for (int i = 5; i < NVEC; i++) begin
            tbl[i].a   = 8'($urandom);
            tbl[i].b   = 8'($urandom);
            tbl[i].cin = 1'($urandom);
            tbl[i].exp = 9'(tbl[i].a) + 9'(tbl[i].b) + 9'(tbl[i].cin);
        end

        // Reset state
        #1;
        chk("rst_outputs", {busy8, done8, cout8, sum8}, 11'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++)
            run_op8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].exp, (i % 2) == 1);

        // start held high: accepts every WIDTH+2 edges, operands from those edges
        last = -1000;
        accepts = 0;
        for (int e = 0; e < 30; e++) begin
            ca = 8'($urandom); cb = 8'($urandom); cc = 1'($urandom);
            a8 = ca; b8 = cb; cin8 = cc; start8 = 1'b1;
            @(posedge clk);
            if (e - last >= W8 + 2) begin
                last = e;
                accepts++;
                expq.push_back(9'(ca) + 9'(cb) + 9'(cc));
            end
            @(negedge clk);
            since = e - last;
            chk("held_busy", busy8, since < W8);
            chk("held_done", done8, since == W8);
            if (since == W8 && expq.size() > 0) held = expq.pop_front();
            chk("held_result", {cout8, sum8}, held);
        end
        start8 = 1'b0;
        chk("held_accepts", 64'(accepts), 64'd3);
        repeat (3) @(negedge clk);

        // Abort after 3 bits with an asynchronous reset between edges
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_outputs", {busy8, done8, cout8, sum8}, 11'h0);
        @(negedge clk);
        rst_n = 1'b1;
        abort_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) abort_done = 1'b1;
        end
        chk("abort_no_done", abort_done, 1'b0);
        chk("abort_sum", {cout8, sum8}, 9'h000);
        held = '0;
        run_op8(8'h12, 8'h34, 1'b1, 9'h047, 1'b0);

        // WIDTH=3 exhaustive
        pulses3 = 0;
        for (int i = 0; i < 128; i++) begin
            logic [6:0] v;
            v = 7'(i);
            run_op3(v[6:4], v[3:1], v[0]);
        end
        repeat (2) @(negedge clk);
        chk("w3_pulses", 64'(pulses3), 64'd128);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
